// File: rtl/id_stage_hazard.sv
// Decode stage: register file with write-through, instruction decode, RAW hazard
// detection against EXE/MEM, in-ID branch resolution and the ID/EXE pipeline register.
module id_stage_hazard #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_CNT    = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned PC_W       = 32,
    parameter bit          FORWARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Instruction,
    input  logic [PC_W-1:0]   PC_in,
    input  logic              In_Valid,
    input  logic              Freeze,
    input  logic [DATA_W-1:0] WB_Data,
    input  logic [REG_AW-1:0] WB_Dest,
    input  logic              WB_Write_Enable,
    input  logic [REG_AW-1:0] EXE_Dest,
    input  logic [REG_AW-1:0] MEM_Dest,
    input  logic              EXE_WB_EN,
    input  logic              MEM_WB_EN,
    input  logic              EXE_MEM_R_EN,
    output logic              Hazard_Stall,
    output logic              IF_Flush,
    output logic              Br_Taken,
    output logic [PC_W-1:0]   Br_Addr,
    output logic              Out_Valid,
    output logic [DATA_W-1:0] Val1,
    output logic [DATA_W-1:0] Val2,
    output logic [DATA_W-1:0] Reg2,
    output logic [REG_AW-1:0] Dest,
    output logic [REG_AW-1:0] Src1,
    output logic [REG_AW-1:0] Src2,
    output logic [3:0]        EXE_CMD,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic              WB_EN
);

    typedef enum logic [5:0] {
        OP_NOP = 6'd0,  OP_ADD = 6'd1,  OP_SUB = 6'd3,   OP_AND = 6'd5,
        OP_OR  = 6'd6,  OP_NOR = 6'd7,  OP_XOR = 6'd8,   OP_SLA = 6'd9,
        OP_SLL = 6'd10, OP_SRA = 6'd11, OP_SRL = 6'd12,  OP_ADDI = 6'd32,
        OP_SUBI = 6'd33, OP_LD = 6'd36, OP_ST = 6'd37,   OP_BEZ = 6'd40,
        OP_BNE = 6'd41, OP_JMP = 6'd42
    } op_e;

    typedef enum logic [3:0] {
        CMD_ADD = 4'b0000, CMD_SUB = 4'b0010, CMD_AND = 4'b0100, CMD_OR  = 4'b0101,
        CMD_NOR = 4'b0110, CMD_XOR = 4'b0111, CMD_SHL = 4'b1000, CMD_SRA = 4'b1001,
        CMD_SRL = 4'b1010, CMD_NOP = 4'b1111
    } cmd_e;

    typedef enum logic [1:0] {BR_NONE = 2'b00, BR_BEZ = 2'b01, BR_BNE = 2'b10, BR_JMP = 2'b11} br_e;

    logic [DATA_W-1:0] regs [REG_CNT];

    op_e               op;
    logic [REG_AW-1:0] dst, s1, s2, p2_idx;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_d, rd1, rd2;
    logic [PC_W-1:0]   imm_pc;
    cmd_e              cmd;
    br_e               br_type;
    logic              mem_r, mem_w, wb_en, is_imm;
    logic              use1, use2, exe_hit, mem_hit, hazard, br_cond, wr_ok;

    assign op     = op_e'(Instruction[31:26]);
    assign dst    = Instruction[21 +: REG_AW];
    assign s1     = Instruction[16 +: REG_AW];
    assign s2     = Instruction[11 +: REG_AW];
    assign imm    = Instruction[15:0];
    assign imm_d  = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_pc = {{(PC_W-16){imm[15]}}, imm};

    always_comb begin
        cmd     = CMD_NOP;
        mem_r   = 1'b0;
        mem_w   = 1'b0;
        wb_en   = 1'b0;
        is_imm  = 1'b0;
        br_type = BR_NONE;
        case (op)
            OP_ADD:  begin cmd = CMD_ADD; wb_en = 1'b1; end
            OP_SUB:  begin cmd = CMD_SUB; wb_en = 1'b1; end
            OP_AND:  begin cmd = CMD_AND; wb_en = 1'b1; end
            OP_OR:   begin cmd = CMD_OR;  wb_en = 1'b1; end
            OP_NOR:  begin cmd = CMD_NOR; wb_en = 1'b1; end
            OP_XOR:  begin cmd = CMD_XOR; wb_en = 1'b1; end
            OP_SLA, OP_SLL: begin cmd = CMD_SHL; wb_en = 1'b1; end
            OP_SRA:  begin cmd = CMD_SRA; wb_en = 1'b1; end
            OP_SRL:  begin cmd = CMD_SRL; wb_en = 1'b1; end
            OP_ADDI: begin cmd = CMD_ADD; wb_en = 1'b1; is_imm = 1'b1; end
            OP_SUBI: begin cmd = CMD_SUB; wb_en = 1'b1; is_imm = 1'b1; end
            OP_LD:   begin cmd = CMD_ADD; wb_en = 1'b1; is_imm = 1'b1; mem_r = 1'b1; end
            OP_ST:   begin cmd = CMD_ADD; is_imm = 1'b1; mem_w = 1'b1; end
            OP_BEZ:  begin is_imm = 1'b1; br_type = BR_BEZ; end
            OP_BNE:  begin is_imm = 1'b1; br_type = BR_BNE; end
            OP_JMP:  begin is_imm = 1'b1; br_type = BR_JMP; end
            default: ;
        endcase
    end

    // Stores and BNE carry their second operand in the dst field
    assign p2_idx = (mem_w || br_type == BR_BNE) ? dst : s2;

    assign wr_ok = WB_Write_Enable && (WB_Dest != '0) && (32'(WB_Dest) < REG_CNT);

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (s1 != '0 && 32'(s1) < REG_CNT)
            rd1 = (wr_ok && WB_Dest == s1) ? WB_Data : regs[s1];
        if (p2_idx != '0 && 32'(p2_idx) < REG_CNT)
            rd2 = (wr_ok && WB_Dest == p2_idx) ? WB_Data : regs[p2_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[WB_Dest] <= WB_Data;
        end
    end

    assign use1    = (br_type != BR_JMP) && (s1 != '0);
    assign use2    = (!is_imm || mem_w || br_type == BR_BNE) && (p2_idx != '0);
    assign exe_hit = EXE_WB_EN && ((use1 && s1 == EXE_Dest) || (use2 && p2_idx == EXE_Dest));
    assign mem_hit = MEM_WB_EN && ((use1 && s1 == MEM_Dest) || (use2 && p2_idx == MEM_Dest));
    assign hazard  = FORWARD_EN ? (exe_hit && EXE_MEM_R_EN) : (exe_hit || mem_hit);

    assign Hazard_Stall = In_Valid && hazard && !Freeze;

    always_comb begin
        br_cond = 1'b0;
        case (br_type)
            BR_BEZ:  br_cond = (rd1 == '0);
            BR_BNE:  br_cond = (rd1 != rd2);
            BR_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign Br_Taken = In_Valid && !Hazard_Stall && !Freeze && br_cond;
    assign IF_Flush = Br_Taken;
    assign Br_Addr  = PC_in + imm_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Out_Valid <= 1'b0;
            Val1      <= '0;
            Val2      <= '0;
            Reg2      <= '0;
            Dest      <= '0;
            Src1      <= '0;
            Src2      <= '0;
            EXE_CMD   <= '0;
            MEM_R_EN  <= 1'b0;
            MEM_W_EN  <= 1'b0;
            WB_EN     <= 1'b0;
        end else if (Freeze) begin
            Out_Valid <= Out_Valid;
        end else if (Hazard_Stall || !In_Valid) begin
            Out_Valid <= 1'b0;
            Val1      <= '0;
            Val2      <= '0;
            Reg2      <= '0;
            Dest      <= '0;
            Src1      <= '0;
            Src2      <= '0;
            EXE_CMD   <= '0;
            MEM_R_EN  <= 1'b0;
            MEM_W_EN  <= 1'b0;
            WB_EN     <= 1'b0;
        end else begin
            Out_Valid <= 1'b1;
            Val1      <= rd1;
            Val2      <= is_imm ? imm_d : rd2;
            Reg2      <= rd2;
            Dest      <= dst;
            Src1      <= s1;
            Src2      <= p2_idx;
            EXE_CMD   <= cmd;
            MEM_R_EN  <= mem_r;
            MEM_W_EN  <= mem_w;
            WB_EN     <= wb_en;
        end
    end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Directed bench for id_stage_hazard; a FORWARD_EN=0 copy shares the inputs
// so both hazard policies are checked against the same vectors.
module tb_id_stage_hazard;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instruction;
    logic [31:0] PC_in;
    logic        In_Valid, Freeze;
    logic [31:0] WB_Data;
    logic [4:0]  WB_Dest, EXE_Dest, MEM_Dest;
    logic        WB_Write_Enable, EXE_WB_EN, MEM_WB_EN, EXE_MEM_R_EN;

    logic        Hazard_Stall, IF_Flush, Br_Taken, Out_Valid, MEM_R_EN, MEM_W_EN, WB_EN;
    logic [31:0] Br_Addr, Val1, Val2, Reg2;
    logic [4:0]  Dest, Src1, Src2;
    logic [3:0]  EXE_CMD;

    logic        f0_stall, f0_flush, f0_taken, f0_valid, f0_mr, f0_mw, f0_wb;
    logic [31:0] f0_addr, f0_v1, f0_v2, f0_r2;
    logic [4:0]  f0_dest, f0_s1, f0_s2;
    logic [3:0]  f0_cmd;

    int n_chk  = 0;
    int n_fail = 0;

    id_stage_hazard #(.FORWARD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .Instruction(Instruction), .PC_in(PC_in), .In_Valid(In_Valid),
        .Freeze(Freeze), .WB_Data(WB_Data), .WB_Dest(WB_Dest), .WB_Write_Enable(WB_Write_Enable),
        .EXE_Dest(EXE_Dest), .MEM_Dest(MEM_Dest), .EXE_WB_EN(EXE_WB_EN), .MEM_WB_EN(MEM_WB_EN),
        .EXE_MEM_R_EN(EXE_MEM_R_EN), .Hazard_Stall(Hazard_Stall), .IF_Flush(IF_Flush),
        .Br_Taken(Br_Taken), .Br_Addr(Br_Addr), .Out_Valid(Out_Valid), .Val1(Val1), .Val2(Val2),
        .Reg2(Reg2), .Dest(Dest), .Src1(Src1), .Src2(Src2), .EXE_CMD(EXE_CMD),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN)
    );

    id_stage_hazard #(.FORWARD_EN(1'b0)) dut_f0 (
        .clk(clk), .rst(rst), .Instruction(Instruction), .PC_in(PC_in), .In_Valid(In_Valid),
        .Freeze(Freeze), .WB_Data(WB_Data), .WB_Dest(WB_Dest), .WB_Write_Enable(WB_Write_Enable),
        .EXE_Dest(EXE_Dest), .MEM_Dest(MEM_Dest), .EXE_WB_EN(EXE_WB_EN), .MEM_WB_EN(MEM_WB_EN),
        .EXE_MEM_R_EN(EXE_MEM_R_EN), .Hazard_Stall(f0_stall), .IF_Flush(f0_flush),
        .Br_Taken(f0_taken), .Br_Addr(f0_addr), .Out_Valid(f0_valid), .Val1(f0_v1), .Val2(f0_v2),
        .Reg2(f0_r2), .Dest(f0_dest), .Src1(f0_s1), .Src2(f0_s2), .EXE_CMD(f0_cmd),
        .MEM_R_EN(f0_mr), .MEM_W_EN(f0_mw), .WB_EN(f0_wb)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] ADD = 6'd1, SUB = 6'd3, ADDI = 6'd32, ST = 6'd37,
                           BEZ = 6'd40, BNE = 6'd41, JMP = 6'd42;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] d,
                                       input logic [4:0] a, input logic [15:0] lo);
        return {op, d, a, lo};
    endfunction

    function automatic logic [15:0] r2(input logic [4:0] b);
        return {b, 11'd0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] v);
        WB_Write_Enable = 1'b1;
        WB_Dest = r;
        WB_Data = v;
        step();
        WB_Write_Enable = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        Instruction = '0; PC_in = '0; In_Valid = 1'b0; Freeze = 1'b0;
        WB_Data = '0; WB_Dest = '0; WB_Write_Enable = 1'b0;
        EXE_Dest = '0; MEM_Dest = '0; EXE_WB_EN = 1'b0; MEM_WB_EN = 1'b0; EXE_MEM_R_EN = 1'b0;
        step();
        chk("reset_valid", Out_Valid, 1'b0);
        chk("reset_wben", WB_EN, 1'b0);
        rst = 1'b1;
        step();

        // ALU op loads operands and controls
        wb(5'd1, 32'd4);
        wb(5'd2, 32'd5);
        Instruction = mk(ADD, 5'd7, 5'd1, r2(5'd2));
        In_Valid = 1'b1;
        step();
        chk("add_valid", Out_Valid, 1'b1);
        chk("add_wben", WB_EN, 1'b1);
        chk("add_val1", Val1, 32'd4);
        chk("add_val2", Val2, 32'd5);
        chk("add_dest", Dest, 5'd7);
        chk("add_src2", Src2, 5'd2);
        chk("add_cmd", EXE_CMD, 4'b0000);

        // asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", Out_Valid, 1'b0);
        chk("arst_wben", WB_EN, 1'b0);
        chk("arst_val1", Val1, 32'd0);
        chk("arst_dest", Dest, 5'd0);
        In_Valid = 1'b0;
        #2 rst = 1'b1;
        step();
        for (int i = 1; i < 32; i++) begin
            Instruction = mk(ADD, 5'd0, i[4:0], r2(i[4:0]));
            In_Valid = 1'b1;
            step();
            chk($sformatf("rst_clear_r%0d", i), {Val1, Val2}, 64'd0);
        end

        // write-through from WB in the same cycle as the read
        WB_Write_Enable = 1'b1; WB_Dest = 5'd5; WB_Data = 32'hDEADBEEF;
        Instruction = mk(ADD, 5'd7, 5'd5, r2(5'd2));
        step();
        WB_Write_Enable = 1'b0;
        chk("wt_val1", Val1, 32'hDEADBEEF);
        chk("wt_valid", Out_Valid, 1'b1);
        Instruction = mk(ADD, 5'd8, 5'd5, r2(5'd5));
        step();
        chk("wt_kept", {Val1, Val2}, {32'hDEADBEEF, 32'hDEADBEEF});

        // load-use hazard
        EXE_WB_EN = 1'b1; EXE_MEM_R_EN = 1'b1; EXE_Dest = 5'd3;
        Instruction = mk(ADD, 5'd4, 5'd3, r2(5'd6));
        #1;
        chk("lu_stall", Hazard_Stall, 1'b1);
        chk("lu_stall_f0", f0_stall, 1'b1);
        chk("lu_taken", Br_Taken, 1'b0);
        step();
        chk("lu_bubble", {Out_Valid, WB_EN}, 2'b00);
        EXE_MEM_R_EN = 1'b0;
        #1;
        chk("alu_nostall", Hazard_Stall, 1'b0);
        chk("alu_stall_f0", f0_stall, 1'b1);
        EXE_WB_EN = 1'b0; MEM_WB_EN = 1'b1; MEM_Dest = 5'd6;
        #1;
        chk("mem_nostall", Hazard_Stall, 1'b0);
        chk("mem_stall_f0", f0_stall, 1'b1);
        MEM_WB_EN = 1'b0;
        EXE_WB_EN = 1'b1; EXE_MEM_R_EN = 1'b1; EXE_Dest = 5'd3;
        Instruction = mk(ADDI, 5'd4, 5'd6, r2(5'd3));
        #1;
        chk("imm_s2_unused", {Hazard_Stall, f0_stall}, 2'b00);
        Instruction = mk(ADD, 5'd4, 5'd3, r2(5'd6));
        Freeze = 1'b1;
        #1;
        chk("freeze_masks_stall", Hazard_Stall, 1'b0);
        Freeze = 1'b0;
        EXE_Dest = 5'd1;
        Instruction = mk(ST, 5'd1, 5'd2, 16'hFFF0);
        #1;
        chk("st_dst_stall", Hazard_Stall, 1'b1);
        EXE_WB_EN = 1'b0; EXE_MEM_R_EN = 1'b0;
        In_Valid = 1'b0;

        // store: Val2 = sext(imm), Reg2 = R[dst]
        wb(5'd1, 32'd4);
        wb(5'd2, 32'd5);
        Instruction = mk(ST, 5'd1, 5'd2, 16'hFFF0);
        In_Valid = 1'b1;
        step();
        chk("st_vals", {Val1, Val2, Reg2}, {32'd5, 32'hFFFFFFF0, 32'd4});
        chk("st_ctl", {MEM_W_EN, MEM_R_EN, WB_EN, Src2}, {3'b100, 5'd1});

        // branches
        PC_in = 32'h40;
        Instruction = mk(BNE, 5'd2, 5'd1, 16'hFFFC);
        #1;
        chk("bne_taken", {Br_Taken, IF_Flush}, 2'b11);
        chk("bne_addr", Br_Addr, 32'h3C);
        step();
        chk("bne_proceeds", {Out_Valid, WB_EN}, 2'b10);
        WB_Write_Enable = 1'b1; WB_Dest = 5'd1; WB_Data = 32'd5;
        #1;
        chk("bne_equal", {Br_Taken, IF_Flush}, 2'b00);
        step();
        WB_Write_Enable = 1'b0;
        Instruction = mk(BEZ, 5'd0, 5'd0, 16'h0010);
        #1;
        chk("bez_r0", {Br_Taken, Br_Addr}, {1'b1, 32'h50});
        Instruction = mk(BEZ, 5'd0, 5'd1, 16'h0010);
        #1;
        chk("bez_nz", Br_Taken, 1'b0);
        In_Valid = 1'b0;
        Instruction = mk(JMP, 5'd0, 5'd0, 16'h0002);
        #1;
        chk("jmp_invalid", Br_Taken, 1'b0);
        In_Valid = 1'b1;

        // freeze holds ID/EXE, regfile still written
        Instruction = mk(ADD, 5'd10, 5'd1, r2(5'd2));
        step();
        Freeze = 1'b1;
        Instruction = mk(JMP, 5'd11, 5'd2, 16'h0002);
        #1;
        chk("freeze_no_branch", Br_Taken, 1'b0);
        WB_Write_Enable = 1'b1; WB_Dest = 5'd9; WB_Data = 32'h99;
        step();
        WB_Write_Enable = 1'b0;
        step();
        step();
        chk("freeze_hold", {Out_Valid, Dest, Val1, Val2, EXE_CMD, WB_EN},
            {1'b1, 5'd10, 32'd5, 32'd5, 4'b0000, 1'b1});
        Freeze = 1'b0;
        Instruction = mk(ADD, 5'd12, 5'd9, r2(5'd0));
        step();
        chk("freeze_wb_r9", {Val1, Dest}, {32'h99, 5'd12});

        // R0 hard-wired to zero
        WB_Write_Enable = 1'b1; WB_Dest = 5'd0; WB_Data = 32'd7;
        Instruction = mk(ADD, 5'd13, 5'd0, r2(5'd0));
        step();
        WB_Write_Enable = 1'b0;
        chk("r0_wt", Val1, 32'd0);
        step();
        chk("r0_read", {Val1, Val2}, 64'd0);
        EXE_WB_EN = 1'b1; EXE_MEM_R_EN = 1'b1; EXE_Dest = 5'd0;
        #1;
        chk("r0_nostall", {Hazard_Stall, f0_stall}, 2'b00);
        EXE_WB_EN = 1'b0; EXE_MEM_R_EN = 1'b0;
        PC_in = 32'hFFFFFFFF;
        Instruction = mk(JMP, 5'd0, 5'd0, 16'h0002);
        #1;
        chk("jmp_wrap", {Br_Taken, Br_Addr}, {1'b1, 32'h1});
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
